// File: rtl/wb_arbiter_2m.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | wb_arbiter_2m : two-master round-robin Wishbone B3 arbiter with watchdog    |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module wb_arbiter_2m #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic              m0_we_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic [2:0]        m0_cti_i,
    input  logic [1:0]        m0_bte_i,
    output logic [DW-1:0]     m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic              m1_we_i,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic [2:0]        m1_cti_i,
    input  logic [1:0]        m1_bte_i,
    output logic [DW-1:0]     m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic              s_we_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic [2:0]        s_cti_o,
    output logic [1:0]        s_bte_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    output logic [1:0]        grant_o,
    output logic              timeout_o
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_G0   = 2'd1;
    localparam logic [1:0] c_ST_G1   = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_last_m1;
    logic       w_last_m1_nxt;
    logic       w_timeout;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_state   <= c_ST_IDLE;
            r_last_m1 <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_last_m1 <= w_last_m1_nxt;
        end
    end

    // Grant is held for the whole CYC; every hand-over passes through IDLE.
    always_comb begin
        w_state_nxt   = r_state;
        w_last_m1_nxt = r_last_m1;
        case (r_state)
            c_ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_nxt = r_last_m1 ? c_ST_G0 : c_ST_G1;
                end else if (m0_cyc_i) begin
                    w_state_nxt = c_ST_G0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = c_ST_G1;
                end
            end
            c_ST_G0: begin
                if (!m0_cyc_i) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_last_m1_nxt = 1'b0;
                end
            end
            c_ST_G1: begin
                if (!m1_cyc_i) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_last_m1_nxt = 1'b1;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        case (r_state)
            c_ST_G0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
                s_we_o  = m0_we_i;
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_cti_o = m0_cti_i;
                s_bte_o = m0_bte_i;
            end
            c_ST_G1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
                s_we_o  = m1_we_i;
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_cti_o = m1_cti_i;
                s_bte_o = m1_bte_i;
            end
            default: ;
        endcase
    end

    assign grant_o   = {r_state == c_ST_G1, r_state == c_ST_G0};
    assign timeout_o = w_timeout;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & grant_o[0];
    assign m1_ack_o = s_ack_i & grant_o[1];
    assign m0_err_o = (s_err_i | w_timeout) & grant_o[0];
    assign m1_err_o = (s_err_i | w_timeout) & grant_o[1];

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam logic [TW-1:0] c_WDOG_LAST = TW'(TIMEOUT - 1);
            logic [TW-1:0] r_wdog;
            logic          w_wdog_clr;

            // A response in the final cycle wins over the watchdog.
            assign w_timeout  = s_stb_o && !s_ack_i && !s_err_i && (r_wdog == c_WDOG_LAST);
            assign w_wdog_clr = !s_stb_o || s_ack_i || s_err_i || w_timeout ||
                                (r_state == c_ST_IDLE);

            always_ff @(posedge wb_clk_i) begin
                if (!wb_rst_n_i || w_wdog_clr) begin
                    r_wdog <= '0;
                end else begin
                    r_wdog <= r_wdog + TW'(1);
                end
            end
        end else begin : g_no_wdog
            assign w_timeout = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_2m.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_wb_arbiter_2m : randomized scoreboard bench for wb_arbiter_2m            |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_wb_arbiter_2m;

    localparam int c_TO = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
    logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
    logic [2:0]  m0_cti_i, m1_cti_i, s_cti_o;
    logic [1:0]  m0_bte_i, m1_bte_i, s_bte_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT(c_TO), .TW(8)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    typedef struct packed {
        logic        err;
        logic        chk;
        logic [31:0] dat;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [73:0] cur_req[2];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          slave_hang = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    // Slave behaviour: data is a fixed function of the address, latency is adr[1:0]
    // (0..3 cycles, always inside the 4-cycle watchdog), region 0xE... answers err.
    function automatic logic [31:0] resp_of(input logic [31:0] adr);
        if (adr == 32'h0000_0010) return 32'hDEAD_BEEF;
        return {adr[15:0], ~adr[31:16]} ^ 32'h0F0F_3C3C;
    endfunction

    function automatic int slave_lat(input logic [31:0] adr);
        if (adr == 32'h0000_0010) return 2;
        return int'(adr[1:0]);
    endfunction

    initial begin : slave_model
        int wait_cnt;
        wait_cnt = 0;
        s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
        forever begin
            @(posedge clk); #2;
            s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
            if (s_cyc_o && s_stb_o) begin
                if (!slave_hang && wait_cnt == slave_lat(s_adr_o)) begin
                    if (s_adr_o[31:28] == 4'hE) s_err_i = 1'b1;
                    else begin s_ack_i = 1'b1; s_dat_i = resp_of(s_adr_o); end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic drive(input int m, input logic act, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input logic we);
        logic [2:0] cti;
        logic [1:0] bte;
        cti = act ? 3'($urandom_range(0, 7)) : 3'd0;
        bte = act ? 2'($urandom_range(0, 3)) : 2'd0;
        cur_req[m] = {adr, dat, sel, we, cti, bte};
        if (m == 0) begin
            m0_cyc_i = act; m0_stb_i = act; m0_adr_i = adr; m0_dat_i = dat;
            m0_sel_i = sel; m0_we_i = we; m0_cti_i = cti; m0_bte_i = bte;
        end else begin
            m1_cyc_i = act; m1_stb_i = act; m1_adr_i = adr; m1_dat_i = dat;
            m1_sel_i = sel; m1_we_i = we; m1_cti_i = cti; m1_bte_i = bte;
        end
    endtask

    // One master cycle: raise cyc/stb, collect nresp responses, then drop cyc.
    task automatic m_access(input int m, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic we, input int nresp);
        exp_t e;
        int   got;
        int   cycles;
        @(posedge clk); #1;
        drive(m, 1'b1, adr, dat, sel, we);
        e.err = slave_hang || (adr[31:28] == 4'hE);
        e.chk = !e.err;
        e.dat = e.err ? 32'h0 : resp_of(adr);
        for (int k = 0; k < nresp; k++) begin
            if (m == 0) q0.push_back(e); else q1.push_back(e);
        end
        got = 0; cycles = 0;
        while (got < nresp && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (m == 0 ? (m0_ack_o || m0_err_o) : (m1_ack_o || m1_err_o)) got++;
        end
        check($sformatf("m%0d_resp_wait", m), got, nresp);
        @(posedge clk); #1;
        drive(m, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic random_master(input int m, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] adr;
            adr = $urandom;
            if (adr == 32'h10) adr = 32'h14;
            m_access(m, adr, $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), 1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
    endtask

    // Scoreboard consumer and reference model of grant order and watchdog timing.
    initial begin : monitor
        exp_t       e;
        logic [1:0] exp_grant, prev_grant;
        logic       prev_c0, prev_c1, prev_rst, last_m1;
        int         age, cur;
        prev_grant = 2'b00; prev_c0 = 0; prev_c1 = 0; prev_rst = 0; last_m1 = 1; age = 0;
        forever begin
            @(negedge clk);
            if (!prev_rst) begin
                exp_grant = 2'b00;
                last_m1   = 1'b1;
            end else if (prev_grant == 2'b00) begin
                if (prev_c0 && prev_c1) exp_grant = last_m1 ? 2'b01 : 2'b10;
                else if (prev_c0)       exp_grant = 2'b01;
                else if (prev_c1)       exp_grant = 2'b10;
                else                    exp_grant = 2'b00;
            end else begin
                exp_grant = (prev_grant[0] ? prev_c0 : prev_c1) ? prev_grant : 2'b00;
                if (exp_grant == 2'b00) last_m1 = prev_grant[1];
            end
            check("grant", grant_o, exp_grant);
            prev_grant = exp_grant;
            prev_c0 = m0_cyc_i; prev_c1 = m1_cyc_i; prev_rst = rst_n;

            if (s_stb_o) begin
                cur = age + 1;
                check("timeout_pulse", timeout_o, (cur == c_TO) && !s_ack_i && !s_err_i);
                age = (s_ack_i || s_err_i || timeout_o) ? 0 : cur;
            end else begin
                age = 0;
            end

            if (s_stb_o && (s_ack_i || s_err_i)) begin
                check("slave_req", {s_cyc_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cti_o, s_bte_o},
                      {1'b1, cur_req[grant_o[1] ? 1 : 0]});
            end

            if (m0_ack_o || m0_err_o) begin
                check("m0_routing", grant_o[0], 1'b1);
                if (q0.size() == 0) check("m0_unexpected", 1'b1, 1'b0);
                else begin
                    e = q0.pop_front();
                    check("m0_err", {m0_ack_o, m0_err_o}, {!e.err, e.err});
                    if (e.chk) check("m0_dat", m0_dat_o, e.dat);
                end
            end
            if (m1_ack_o || m1_err_o) begin
                check("m1_routing", grant_o[1], 1'b1);
                if (q1.size() == 0) check("m1_unexpected", 1'b1, 1'b0);
                else begin
                    e = q1.pop_front();
                    check("m1_err", {m1_ack_o, m1_err_o}, {!e.err, e.err});
                    if (e.chk) check("m1_dat", m1_dat_o, e.dat);
                end
            end
        end
    end

    initial begin : time_limit
        #500000;
        $display("FAIL time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        rst_n = 1'b0;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        m0_cyc_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_grant", grant_o, 2'b00);
            check("rst_s_cyc", s_cyc_o, 1'b0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); check("post_rst_idle", grant_o, 2'b00);
        @(negedge clk); check("first_grant", grant_o, 2'b01);
        @(posedge clk); #1 m0_cyc_i = 1'b0;
        repeat (2) @(posedge clk);

        m_access(0, 32'h0000_0010, 32'h0, 4'hF, 1'b0, 1);
        repeat (2) @(posedge clk);

        fork
            m_access(0, 32'h0000_0103, 32'h5555_AAAA, 4'hF, 1'b0, 1);
            begin
                @(posedge clk);
                m_access(1, 32'h9000_0000, 32'h0000_1234, 4'b0011, 1'b1, 1);
            end
        join
        repeat (2) @(posedge clk);

        fork
            for (int i = 0; i < 3; i++) m_access(0, 32'h100 + 32'(i), 32'(i), 4'hF, 1'b0, 1);
            for (int i = 0; i < 3; i++) m_access(1, 32'h200 + 32'(i), 32'(i), 4'hF, 1'b1, 1);
        join
        repeat (2) @(posedge clk);

        fork
            random_master(0, 12);
            random_master(1, 12);
        join
        repeat (2) @(posedge clk);

        m_access(1, 32'h3000_3003, 32'hCAFE_F00D, 4'hF, 1'b1, 1);
        m_access(0, 32'hE000_0001, 32'h0, 4'hF, 1'b0, 1);

        slave_hang = 1'b1;
        m_access(0, 32'h0000_2000, 32'h0, 4'hF, 1'b0, 2);

        @(posedge clk); #1 drive(0, 1'b1, 32'h4000_0000, 32'h1, 4'hF, 1'b1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_grant", grant_o, 2'b00);
        check("midrst_s_cyc", s_cyc_o, 1'b0);
        check("midrst_no_resp", {m0_ack_o, m0_err_o}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        slave_hang = 1'b0;
        repeat (3) @(posedge clk);

        m_access(1, 32'h0000_0042, 32'h0, 4'hF, 1'b0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
